// File: rtl/bcd_7seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: active-low
// segment patterns {g,f,e,d,c,b,a}, digit count and a nibble decode helper.
package bcd_7seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam int NUM_DIGITS = 4;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Non-BCD nibbles (10..15) show a dash so corrupt input is visible.
  function automatic seg_t digit_pattern(input logic [3:0] nibble);
    seg_t pat;
    case (nibble)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_7seg_scan_if.sv
// Display-side bundle: BCD capture inputs from the converter and the
// multiplexed anode/segment/frame outputs toward the display.
interface bcd_7seg_scan_if;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame;

  modport master (
    output load, bcd_in, blank_en,
    input  an, seg, frame
  );

  modport slave (
    input  load, bcd_in, blank_en,
    output an, seg, frame
  );
endinterface

// File: rtl/bcd_7seg_scan_dec.sv
// Combinational nibble-to-segment decoder with a blank override; the blank
// flag is only raised for leading zeros, so dashes are never suppressed.
module bcd_to_7seg
  import bcd_7seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = digit_pattern(i_nibble);
    if (i_blank) o_seg = SEG_BLANK;
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Four-digit common-anode scanner: holds the captured BCD word, steps one
// digit every DIV clocks and registers anode/segment/frame outputs.
module bcd_7seg_scan
  import bcd_7seg_scan_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int CW  = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bcd_7seg_scan_if.slave bus
);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame;

  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic [3:0]    w_zero;
  logic [3:0]    w_lead_zero;
  logic          w_blank;
  logic [6:0]    w_seg;

  assign w_wrap = (r_cnt == CW'(DIV - 1));

  always_comb begin
    w_nibble = r_disp[3:0];
    case (r_idx)
      2'd0: w_nibble = r_disp[3:0];
      2'd1: w_nibble = r_disp[7:4];
      2'd2: w_nibble = r_disp[11:8];
      2'd3: w_nibble = r_disp[15:12];
      default: w_nibble = r_disp[3:0];
    endcase
  end

  // A digit is a leading zero only if it and every more significant digit
  // are zero; the ones digit always shows something.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_zero[k] = (r_disp[4*k +: 4] == 4'd0);
    end
    w_lead_zero[3] = w_zero[3];
    w_lead_zero[2] = w_zero[3] & w_zero[2];
    w_lead_zero[1] = w_zero[3] & w_zero[2] & w_zero[1];
    w_lead_zero[0] = 1'b0;
  end

  assign w_blank = bus.blank_en & w_lead_zero[r_idx];

  bcd_to_7seg u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_disp <= 16'h0000;
    end else begin
      if (bus.load) r_disp <= bus.bcd_in;
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Outputs lag idx/disp by one clock; anode stays on for blanked digits so
  // every digit gets the same dwell.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an    <= 4'b1110;
      r_seg   <= SEG_0;
      r_frame <= 1'b0;
    end else begin
      r_an    <= ~(4'b0001 << r_idx);
      r_seg   <= w_seg;
      r_frame <= w_wrap & (r_idx == 2'd3);
    end
  end

  assign bus.an    = r_an;
  assign bus.seg   = r_seg;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Self-checking bench for bcd_7seg_scan with DIV=4: a cycle model pushes the
// expected registered outputs into a queue, popped after each clock edge.
module tb_bcd_7seg_scan;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_7seg_scan_if bus ();

  bcd_7seg_scan #(.DIV(DIV), .CW(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt, m_idx;
  logic [15:0] m_disp;
  logic [6:0]  seen[4];
  int          cyc = 0;
  int          last_frame = -1;
  int          frame_count = 0;

  function automatic logic [6:0] ref_digit(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] d, input int k, input logic ben);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = k; j < 4; j++) if (d[4*j +: 4] != 4'd0) all_zero = 1'b0;
    if (ben && k > 0 && all_zero) return 7'b1111111;
    return ref_digit(d[4*k +: 4]);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_disp = 16'h0000;
    last_frame = -1;
  endtask

  task automatic step(input string tag);
    exp_t e, got;
    e.an    = ~(4'b0001 << m_idx);
    e.seg   = ref_seg(m_disp, m_idx, bus.blank_en);
    e.frame = (m_cnt == DIV - 1) && (m_idx == 3);
    sb_q.push_back(e);
    if (bus.load) m_disp = bus.bcd_in;
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) if (bus.an == ~(4'b0001 << k)) seen[k] = bus.seg;
    got = sb_q.pop_front();
    checks++;
    if (bus.an !== got.an || bus.seg !== got.seg || bus.frame !== got.frame) begin
      errors++;
      $display("FAIL %s cyc=%0d: an=%b seg=%b frame=%b expected an=%b seg=%b frame=%b",
               tag, cyc, bus.an, bus.seg, bus.frame, got.an, got.seg, got.frame);
    end
    if (bus.frame === 1'b1) begin
      frame_count++;
      if (last_frame >= 0) begin
        checks++;
        if (cyc - last_frame !== 4 * DIV) begin
          errors++;
          $display("FAIL %s frame_spacing: got %0d expected %0d", tag, cyc - last_frame, 4 * DIV);
        end
      end
      last_frame = cyc;
    end
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) seen[k] = 7'bxxxxxxx;
  endtask

  // Counts edges after the current point until an leaves 1110.
  task automatic edges_until_advance(input string tag, input int expected);
    int n;
    n = 0;
    while (bus.an === 4'b1110 && n < 20) begin
      step(tag);
      n++;
    end
    checks++;
    if (n !== expected) begin
      errors++;
      $display("FAIL %s advance_edges: got %0d expected %0d", tag, n, expected);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] want[4];
    want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        errors++;
        $display("FAIL %s digit%0d: seg=%b expected %b", tag, k, seen[k], want[k]);
      end
    end
  endtask

  task automatic load_value(input string tag, input logic [15:0] v, input logic ben);
    bus.blank_en = ben;
    bus.bcd_in = v;
    bus.load = 1'b1;
    step(tag);
    bus.load = 1'b0;
    step(tag);
    clear_seen();
    for (int i = 0; i < 4 * DIV; i++) step(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b0;
    bus.bcd_in = 16'h0000;
    bus.blank_en = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: an=%b seg=%b frame=%b expected 1110 1000000 0",
               bus.an, bus.seg, bus.frame);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // idx advances on the 4th edge, visible on an one edge later.
    edges_until_advance("reset_release", 5);
    for (int i = 0; i < 40; i++) step("free_scan");
    checks++;
    if (frame_count < 2) begin
      errors++;
      $display("FAIL free_scan frame_count: got %0d expected >=2", frame_count);
    end
  endtask

  task automatic test_load_15();
    load_value("load_15", 16'h0015, 1'b0);
    check_digits("load_15", 7'b0010010, 7'b1111001, 7'b1000000, 7'b1000000);
  endtask

  task automatic test_blank();
    load_value("blank_15", 16'h0015, 1'b1);
    check_digits("blank_15", 7'b0010010, 7'b1111001, 7'b1111111, 7'b1111111);
    load_value("blank_zero", 16'h0000, 1'b1);
    check_digits("blank_zero", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
    clear_seen();
    bus.blank_en = 1'b0;
    for (int i = 0; i < 4 * DIV + 1; i++) step("blank_off");
    check_digits("blank_off", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
  endtask

  task automatic test_dash();
    load_value("dash", 16'h40A5, 1'b1);
    check_digits("dash", 7'b0010010, 7'b0111111, 7'b1000000, 7'b0011001);
    load_value("dash_lead", 16'h00F0, 1'b1);
    check_digits("dash_lead", 7'b1000000, 7'b0111111, 7'b1111111, 7'b1111111);
  endtask

  task automatic test_rst_mid();
    int n;
    bus.bcd_in = 16'h9876;
    bus.load = 1'b1;
    step("rst_mid_load");
    bus.load = 1'b0;
    n = 0;
    while (m_idx != 2 && n < 40) begin
      step("rst_mid_seek");
      n++;
    end
    step("rst_mid_seek");
    rst = 1'b1;
    #1;
    checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.frame !== 1'b0
        || dut.r_disp !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_async: an=%b seg=%b frame=%b disp=%h expected 1110 1000000 0 0000",
               bus.an, bus.seg, bus.frame, dut.r_disp);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    edges_until_advance("rst_mid_release", 5);
    for (int i = 0; i < 20; i++) step("rst_mid_scan");
  endtask

  task automatic test_back_to_back();
    int f0;
    bus.blank_en = 1'b1;
    bus.load = 1'b1;
    bus.bcd_in = 16'h1234;
    step("b2b");
    bus.bcd_in = 16'h4095;
    step("b2b");
    bus.load = 1'b0;
    bus.bcd_in = 16'h1111;
    f0 = frame_count;
    clear_seen();
    for (int i = 0; i < 40; i++) step("b2b_scan");
    check_digits("b2b", 7'b0010010, 7'b0010000, 7'b1000000, 7'b0011001);
    checks++;
    if (frame_count - f0 < 2) begin
      errors++;
      $display("FAIL b2b frame_count: got %0d expected >=2", frame_count - f0);
    end
  endtask

  initial begin
    test_reset();
    test_load_15();
    test_blank();
    test_dash();
    test_rst_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
